// File: rtl/ssl_frame_ctrl_if.sv
// Bundles the frame sequencer's control, datapath-enable and result handshake signals.
// master = frame controller side, slave = host/consumer side.
interface ssl_frame_ctrl_if #(
    parameter int NDATA_LOG = 7
);
    logic                 start;
    logic                 cont;
    logic [NDATA_LOG-1:0] dIdA;
    logic [NDATA_LOG-1:0] dIdB;
    logic [NDATA_LOG-1:0] dIdC;
    logic                 ena;
    logic                 clr;
    logic                 busy;
    logic                 res_valid;
    logic                 res_ready;
    logic [NDATA_LOG-1:0] resA;
    logic [NDATA_LOG-1:0] resB;
    logic [NDATA_LOG-1:0] resC;
    logic [7:0]           frame_cnt;
    logic                 ovr;

    modport master (
        input  start, cont, dIdA, dIdB, dIdC, res_ready,
        output ena, clr, busy, res_valid, resA, resB, resC, frame_cnt, ovr
    );

    modport slave (
        output start, cont, dIdA, dIdB, dIdC, res_ready,
        input  ena, clr, busy, res_valid, resA, resB, resC, frame_cnt, ovr
    );
endinterface

// File: rtl/ssl_frame_ctrl.sv
// Frame sequencer: CLEAR -> CAPTURE(NDATA) -> PROCESS(PROC_CYC) -> LATCH, single-shot or continuous.
// Latency: res_valid rises NDATA+PROC_CYC+3 cycles after the start edge; all outputs registered.
// Backpressure: a result arriving while the previous one is unaccepted is dropped and sets sticky ovr.
// Optional SSL_AVG_EN: publish the floor-average of every 2^AVG_LOG frames instead of each frame.
module ssl_frame_ctrl #(
    parameter int NDATA     = 128,
    parameter int NDATA_LOG = $clog2(NDATA),
    parameter int PROC_CYC  = 128
`ifdef SSL_AVG_EN
    ,
    parameter int AVG_LOG   = 2
`endif
) (
    input  logic               clk,
    input  logic               rst,
    ssl_frame_ctrl_if.master   bus
);
    localparam int CNT_MAX = (NDATA > PROC_CYC) ? NDATA : PROC_CYC;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] CAP_LAST = CW'(NDATA - 1);
    localparam logic [CW-1:0] PRC_LAST = CW'(PROC_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_CAPTURE,
        S_PROCESS,
        S_LATCH
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic                 ena_q, clr_q, busy_q, vld_q, ovr_q;
    logic [NDATA_LOG-1:0] res_a_q, res_b_q, res_c_q;
    logic [7:0]           fcnt_q;

    logic                 pub_d;
    logic [NDATA_LOG-1:0] res_a_d, res_b_d, res_c_d;

`ifdef SSL_AVG_EN
    localparam int AW = NDATA_LOG + AVG_LOG;
    logic [AW-1:0]      acc_a_q, acc_b_q, acc_c_q;
    logic [AW-1:0]      sum_a_d, sum_b_d, sum_c_d;
    logic [AVG_LOG-1:0] grp_q;

    // grp_q all-ones marks the last frame of the averaging group
    always_comb begin
        sum_a_d = acc_a_q + AW'(bus.dIdA);
        sum_b_d = acc_b_q + AW'(bus.dIdB);
        sum_c_d = acc_c_q + AW'(bus.dIdC);
        pub_d   = &grp_q;
        res_a_d = sum_a_d[AW-1:AVG_LOG];
        res_b_d = sum_b_d[AW-1:AVG_LOG];
        res_c_d = sum_c_d[AW-1:AVG_LOG];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_a_q <= '0;
            acc_b_q <= '0;
            acc_c_q <= '0;
            grp_q   <= '0;
        end else if (state_q == S_IDLE && bus.start) begin
            acc_a_q <= '0;
            acc_b_q <= '0;
            acc_c_q <= '0;
            grp_q   <= '0;
        end else if (state_q == S_LATCH) begin
            acc_a_q <= pub_d ? '0 : sum_a_d;
            acc_b_q <= pub_d ? '0 : sum_b_d;
            acc_c_q <= pub_d ? '0 : sum_c_d;
            grp_q   <= grp_q + 1'b1;
        end
    end
`else
    always_comb begin
        pub_d   = 1'b1;
        res_a_d = bus.dIdA;
        res_b_d = bus.dIdB;
        res_c_d = bus.dIdC;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ena_q   <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
            res_a_q <= '0;
            res_b_q <= '0;
            res_c_q <= '0;
            fcnt_q  <= '0;
        end else begin
            clr_q <= 1'b0;
            // a publish in LATCH below overrides this drop
            if (vld_q && bus.res_ready) vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_CLEAR;
                        clr_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        ovr_q   <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_CAPTURE;
                    ena_q   <= 1'b1;
                    cnt_q   <= '0;
                end
                S_CAPTURE: begin
                    if (cnt_q == CAP_LAST) begin
                        state_q <= S_PROCESS;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PROCESS: begin
                    if (cnt_q == PRC_LAST) begin
                        state_q <= S_LATCH;
                        ena_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_LATCH: begin
                    fcnt_q <= fcnt_q + 8'd1;
                    if (pub_d) begin
                        if (!vld_q || bus.res_ready) begin
                            res_a_q <= res_a_d;
                            res_b_q <= res_b_d;
                            res_c_q <= res_c_d;
                            vld_q   <= 1'b1;
                        end else begin
                            ovr_q <= 1'b1;
                        end
                    end
                    if (bus.cont) begin
                        state_q <= S_CLEAR;
                        clr_q   <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ena       = ena_q;
    assign bus.clr       = clr_q;
    assign bus.busy      = busy_q;
    assign bus.res_valid = vld_q;
    assign bus.resA      = res_a_q;
    assign bus.resB      = res_b_q;
    assign bus.resC      = res_c_q;
    assign bus.frame_cnt = fcnt_q;
    assign bus.ovr       = ovr_q;
endmodule

// File: doc/ssl_frame_ctrl.md
# ssl_frame_ctrl

Frame sequencer for the sound source localization datapath. Gates the master enable to the counter, input buffer and the three processor arrays, and issues a clear pulse before each capture window. After a fixed processing interval it latches the three delay indices into a valid/ready result port. Sits between the reset synchronizer/host logic and the ssl datapath, and supports single-shot or continuous frame runs.

## Interface
- NDATA, 128: samples per capture window; must be a power of two and at least 4.
- NDATA_LOG, $clog2(NDATA): width of delay indices.
- PROC_CYC, 128: processing cycles after capture before results are latched; must be at least 1.
- AVG_LOG, 2: log2 of frames averaged; used only with SSL_AVG_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  run request; sampled only in IDLE.
- cont  in  1  continuous mode; sampled in LATCH.
- dIdA, dIdB, dIdC  in  NDATA_LOG each  delay indices from the processor arrays.
- ena  out  1  datapath enable.
- clr  out  1  one-cycle clear to the processor arrays.
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- resA, resB, resC  out  NDATA_LOG each  published delay indices.
- frame_cnt  out  8  number of completed frames; wraps 255→0.
- ovr  out  1  sticky overrun flag.

## Operation
- States: IDLE, CLEAR, CAPTURE, PROCESS, LATCH.
- IDLE: ena=0. start=1 → CLEAR.
- CLEAR: clr=1, ena=0, internal cycle counter zeroed → CAPTURE.
- CAPTURE: ena=1 for exactly NDATA cycles → PROCESS.
- PROCESS: ena=1 for exactly PROC_CYC cycles → LATCH.
- LATCH: ena=0. dIdA/B/C are sampled and frame_cnt increments. Next state is CLEAR if cont=1, otherwise IDLE.
- Publishing at LATCH: if res_valid=0, or res_valid=1 and res_ready=1, the sampled values load into resA/B/C and res_valid is 1 next cycle.
- Dropped frame at LATCH: if res_valid=1 and res_ready=0, the new values are discarded, resA/B/C are held, and ovr is set. frame_cnt still increments.
- ovr clears only on reset or on an IDLE→CLEAR transition.
- Handshake: a transfer occurs when res_valid and res_ready are both high. res_valid falls the next cycle unless a new result loads in that same cycle. resA/B/C are stable while res_valid=1.
- start outside IDLE is ignored. cont falling mid-frame lets the current frame finish, then the block goes to IDLE.
- Reset values: every output 0, state IDLE, accumulators 0. Reset mid-frame aborts the frame with no partial result.

## Timing
- start high at edge k (in IDLE): CLEAR in cycle k+1, CAPTURE in k+2..k+1+NDATA, PROCESS in k+2+NDATA..k+1+NDATA+PROC_CYC, LATCH in k+2+NDATA+PROC_CYC.
- res_valid rises in cycle k+3+NDATA+PROC_CYC, which is k+259 with defaults.
- Continuous mode: frame period is NDATA+PROC_CYC+2 cycles (258 with defaults); CLEAR follows LATCH directly.
- clr and ena are never high in the same cycle.
- All outputs are registered.

## Configuration
- SSL_AVG_EN defined: three accumulators of width NDATA_LOG+AVG_LOG sum dIdA/B/C at each LATCH.
  - On the 2^AVG_LOG-th LATCH, the candidate result is sum>>AVG_LOG (floor). Publish/drop rules apply to this candidate, and the accumulators reset.
  - On other LATCH cycles nothing is published and ovr is not checked.
  - Accumulators and the frame-in-group count clear in CLEAR entered from IDLE.
- SSL_AVG_EN undefined: every frame is published directly, and no accumulator logic is synthesized.

## Test plan
- Reset then single shot: rst=0 for 2 cycles, start pulse at cycle 10 with dIdA/B/C=5/17/100 → res_valid rises at cycle 269, resA/B/C=5/17/100, frame_cnt=1, busy=0 after LATCH.
- Backpressure: cont=1, res_ready=0 for 3 frames → first result held, ovr=1 after the 2nd LATCH, frame_cnt=3; then res_ready=1 for one cycle → res_valid=0 in the following cycle.
- Simultaneous accept: at LATCH, res_valid=1 and res_ready=1 → new values load, res_valid stays 1, ovr stays 0.
- Reset mid-CAPTURE: rst=0 at cycle 50 → next cycle ena=0, res_valid=0, frame_cnt=0, state IDLE; start is ignored while busy=1.
- SSL_AVG_EN with AVG_LOG=2: dIdA=10,11,12,14 over 4 continuous frames → single publish with resA=11; no res_valid after frames 1–3.
- frame_cnt wrap: 256 continuous frames with res_ready=1 → frame_cnt=0, ovr=0.
